md_ctrl: RTL and testbench

- Sequences the shared HI/LO multiply/divide resource in the E stage of the 5-stage pipeline.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO per issue and models the fixed multi-cycle latency with a counter and state machine.
- Commits results to HI/LO and generates the stall request the hazard unit ORs into its pause output whenever the D-stage instruction needs HI/LO.

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_if.sv | 32 +++
 rtl/md_alu.sv | 41 ++++
 rtl/md_ctrl.sv | 133 +++++++++++++
 tb/tb_md_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes, FSM
// encodings, counter width and the ALU result record.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MBUSY = 2'd1;
    localparam logic [1:0] DBUSY = 2'd2;

    localparam int MD_CNT_W = 4;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

endpackage

// File: rtl/md_if.sv
// E-stage md request/response bundle. The cancel signal exists only when the
// design is built with MD_CANCEL_EN.
interface md_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic        md_pause;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MD_CANCEL_EN
    logic        cancel;
`endif

    modport master (
        output start, md_op, rs_val, rt_val, md_use_D,
`ifdef MD_CANCEL_EN
        output cancel,
`endif
        input  busy, md_pause, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, md_use_D,
`ifdef MD_CANCEL_EN
        input  cancel,
`endif
        output busy, md_pause, hi, lo
    );
endinterface

// File: rtl/md_alu.sv
// Combinational multiply/divide datapath. Quotient lands in lo, remainder in
// hi; divide by zero yields zero here and is filtered out by the controller.
module md_alu
    import md_pkg::*;
(
    input  logic [2:0]  md_op_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    output md_res_t     res_o
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               rt_zero;

    assign prod_s  = $signed({{32{rs_val_i[31]}}, rs_val_i}) * $signed({{32{rt_val_i[31]}}, rt_val_i});
    assign prod_u  = {32'd0, rs_val_i} * {32'd0, rt_val_i};
    assign rt_zero = (rt_val_i == 32'd0);

    always_comb begin
        res_o = '0;
        case (md_op_i)
            MD_MULT:  res_o = prod_s;
            MD_MULTU: res_o = prod_u;
            MD_DIV: begin
                if (!rt_zero) begin
                    res_o.lo = $signed(rs_val_i) / $signed(rt_val_i);
                    res_o.hi = $signed(rs_val_i) % $signed(rt_val_i);
                end
            end
            MD_DIVU: begin
                if (!rt_zero) begin
                    res_o.lo = rs_val_i / rt_val_i;
                    res_o.hi = rs_val_i % rt_val_i;
                end
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO multiply/divide sequencer for the E stage. Build option MD_CANCEL_EN
// adds a cancel input that aborts in-flight ops and suppresses new starts.
//
// state | meaning
// IDLE  | no op in flight; MTHI/MTLO write directly
// MBUSY | multiply in flight, cnt counts down to commit
// DBUSY | divide in flight, cnt counts down to commit
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

    logic [1:0]          state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]         hi_q, hi_d, lo_q, lo_d;
    logic [31:0]         pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic                pend_wr_q, pend_wr_d;
    logic                cancel_w;
    md_res_t             alu_res;

`ifdef MD_CANCEL_EN
    assign cancel_w = bus.cancel;
`else
    assign cancel_w = 1'b0;
`endif

    md_alu u_alu (
        .md_op_i  (bus.md_op),
        .rs_val_i (bus.rs_val),
        .rt_val_i (bus.rt_val),
        .res_o    (alu_res)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !cancel_w) begin
                    case (bus.md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_d = alu_res.hi;
                            pend_lo_d = alu_res.lo;
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LD;
                            state_d   = MBUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_hi_d = alu_res.hi;
                            pend_lo_d = alu_res.lo;
                            // A zero divisor still takes the full latency but never commits.
                            pend_wr_d = (bus.rt_val != 32'd0);
                            cnt_d     = DIV_LD;
                            state_d   = DBUSY;
                        end
                        MD_MTHI: hi_d = bus.rs_val;
                        MD_MTLO: lo_d = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            MBUSY, DBUSY: begin
                if (cancel_w) begin
                    pend_wr_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (cnt_q == MD_CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    pend_wr_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && bus.start && state_q != IDLE)
            $error("md_ctrl: start while busy, op ignored");
    end
`endif

    assign bus.busy     = (state_q != IDLE);
    assign bus.md_pause = bus.md_use_D && (bus.busy || bus.start);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed table, multi-cycle corner cases and
// randomized traffic against a cycle-count reference model.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    md_if bus ();

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: an op started at edge e is busy until edge e+N, where it commits.
    int          cyc = 0;
    int          done_at = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0;
    logic [31:0] pend_hi = 0, pend_lo = 0;
    logic        pend_ok = 0;
    logic        last_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic model_start(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint a, b, p;
        int     sa, sb;
        case (op)
            MD_MULT: begin
                sa = rs; sb = rt; a = sa; b = sb; p = a * b;
                pend_hi = p[63:32]; pend_lo = p[31:0]; pend_ok = 1; done_at = cyc + MC;
            end
            MD_MULTU: begin
                a = {32'd0, rs}; b = {32'd0, rt}; p = a * b;
                pend_hi = p[63:32]; pend_lo = p[31:0]; pend_ok = 1; done_at = cyc + MC;
            end
            MD_DIV: begin
                sa = rs; sb = rt;
                pend_ok = (sb != 0);
                if (sb != 0) begin pend_lo = sa / sb; pend_hi = sa % sb; end
                done_at = cyc + DC;
            end
            MD_DIVU: begin
                pend_ok = (rt != 0);
                if (rt != 0) begin pend_lo = rs / rt; pend_hi = rs % rt; end
                done_at = cyc + DC;
            end
            MD_MTHI: exp_hi = rs;
            MD_MTLO: exp_lo = rs;
            default: ;
        endcase
    endtask

    task automatic step(input logic st, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic ud, input logic can);
        logic busy_pre;
        @(negedge clk);
        bus.start = st; bus.md_op = op; bus.rs_val = rs; bus.rt_val = rt; bus.md_use_D = ud;
`ifdef MD_CANCEL_EN
        bus.cancel = can;
`endif
        #1;
        busy_pre = (cyc < done_at);
        last_busy = bus.busy;
        chk("busy", {31'd0, bus.busy}, {31'd0, busy_pre});
        chk("md_pause", {31'd0, bus.md_pause}, {31'd0, ud && (busy_pre || st)});
        chk("hi", bus.hi, exp_hi);
        chk("lo", bus.lo, exp_lo);
        @(posedge clk);
        cyc++;
        if (busy_pre) begin
            if (can) begin
                done_at = cyc; pend_ok = 0;
            end else if (cyc == done_at && pend_ok) begin
                exp_hi = pend_hi; exp_lo = pend_lo;
            end
        end else if (st && !can) begin
            model_start(op, rs, rt);
        end
    endtask

    task automatic idle(input logic ud);
        step(1'b0, 3'd0, 32'd0, 32'd0, ud, 1'b0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs, rt, hi, lo;
        int          n;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int          nb;
        logic [31:0] rs, rt, sv_hi, sv_lo;
        logic [2:0]  op;
        logic        st, ud, can;

        tbl[0] = '{MD_MTHI,  32'hA,         32'h0,        32'hA,         32'h0,         0};
        tbl[1] = '{MD_MTLO,  32'hB,         32'h0,        32'hA,         32'hB,         0};
        tbl[2] = '{MD_DIV,   32'd5,         32'd0,        32'hA,         32'hB,         DC};
        tbl[3] = '{MD_MULT,  32'hFFFFFFFD,  32'd5,        32'hFFFFFFFF,  32'hFFFFFFF1,  MC};
        tbl[4] = '{MD_MULTU, 32'hFFFFFFFD,  32'd5,        32'h00000004,  32'hFFFFFFF1,  MC};
        tbl[5] = '{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        DC};
        tbl[6] = '{MD_DIV,   32'd7,         32'hFFFFFFFE, 32'd1,         32'hFFFFFFFD,  DC};
        tbl[7] = '{MD_MTHI,  32'h1234,      32'h0,        32'h1234,      32'hFFFFFFFD,  0};
        tbl[8] = '{3'd7,     32'h55,        32'h66,       32'h1234,      32'hFFFFFFFD,  0};

        reset = 1'b0;
        bus.start = 0; bus.md_op = 0; bus.rs_val = 0; bus.rt_val = 0; bus.md_use_D = 0;
`ifdef MD_CANCEL_EN
        bus.cancel = 0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table: each op's result and busy length.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, tbl[i].op, tbl[i].rs, tbl[i].rt, 1'b0, 1'b0);
            nb = 0;
            for (int k = 0; k <= 20; k++) begin
                if (k == 20) begin
                    chk("busy_timeout", 32'd1, 32'd0);
                    break;
                end
                idle(1'b0);
                if (!last_busy) break;
                nb++;
            end
            #1;
            chk("tbl_busy_len", nb, tbl[i].n);
            chk("tbl_hi", bus.hi, tbl[i].hi);
            chk("tbl_lo", bus.lo, tbl[i].lo);
        end

        // MULT followed by an MFLO in D: stall covers start plus all busy cycles.
        step(1'b1, MD_MULT, 32'd6, 32'd7, 1'b1, 1'b0);
        repeat (MC + 1) idle(1'b1);
        #1;
        chk("mflo_lo", bus.lo, 32'd42);
        chk("mflo_pause_released", {31'd0, bus.md_pause}, 32'd0);

        // Async reset in the fourth DBUSY cycle.
        step(1'b1, MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
        repeat (3) idle(1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        exp_hi = 0; exp_lo = 0; pend_ok = 0; done_at = cyc;
        @(negedge clk);
        reset = 1'b1;

`ifdef MD_CANCEL_EN
        step(1'b1, MD_MTHI, 32'h77, 32'd0, 1'b0, 1'b0);
        sv_hi = 32'h77; sv_lo = 32'd0;
        step(1'b1, MD_MULT, 32'd9, 32'd9, 1'b0, 1'b0);
        idle(1'b0); idle(1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        #1;
        chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
        repeat (MC) idle(1'b0);
        #1;
        chk("cancel_hi", bus.hi, sv_hi);
        chk("cancel_lo", bus.lo, sv_lo);
        step(1'b1, MD_MULT, 32'd3, 32'd3, 1'b0, 1'b0);
        repeat (MC - 1) idle(1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        idle(1'b0);
        #1;
        chk("cancel_cnt1_lo", bus.lo, sv_lo);
        step(1'b1, MD_MTLO, 32'hDEAD, 32'd0, 1'b0, 1'b1);
        idle(1'b0);
        #1;
        chk("cancel_mtlo_lo", bus.lo, sv_lo);
`endif

        // Randomized traffic; starts are only issued when the model says idle.
        for (int i = 0; i < 500; i++) begin
            op = 3'($urandom_range(0, 7));
            rs = $urandom;
            rt = $urandom;
            if ($urandom_range(0, 3) == 0) rs = 32'($urandom_range(0, 40)) - 32'd20;
            if ($urandom_range(0, 3) == 0) rt = 32'($urandom_range(0, 40)) - 32'd20;
            if ($urandom_range(0, 7) == 0) rt = 32'd0;
            if (rs == 32'h80000000 && rt == 32'hFFFFFFFF) rt = 32'd3;
            st  = (cyc >= done_at) && ($urandom_range(0, 2) == 0);
            ud  = 1'($urandom_range(0, 1));
            can = 1'b0;
`ifdef MD_CANCEL_EN
            can = ($urandom_range(0, 11) == 0);
`endif
            step(st, op, rs, rt, ud, can);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
